// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Streams 32-bit instruction words into instruction memory at
//               consecutive word addresses, then primes the core PC with the
//               program base and releases the core via tbStart/initInstAddr.
//               Optional trailer checksum stage: INST_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadStart,
  input  logic [31:0]      baseAddr,
  input  logic [CNT_W-1:0] wordCount,
  input  logic [31:0]      inData,
  input  logic             inValid,
  output logic             inReady,
  output logic             memWrEn,
  output logic [31:0]      memWrAddr,
  output logic [31:0]      memWrData,
  output logic             tbStart,
  output logic [31:0]      initInstAddr,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHK   = 3'd2,
    S_PRIME = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH_WORDS);

`ifdef INST_LOADER_CHECKSUM_EN
  // The last program word is followed by a checksum trailer.
  localparam state_t c_loadDone = S_CHK;
`else
  localparam state_t c_loadDone = S_PRIME;
`endif

  state_t           r_state;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic             r_inReady;
  logic             r_memWrEn;
  logic [31:0]      r_memWrAddr;
  logic [31:0]      r_memWrData;
  logic             r_tbStart;
  logic [31:0]      r_initInstAddr;
  logic             r_busy;
  logic             r_error;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]      r_csum;
`endif

  state_t w_next;
  logic   w_start;
  logic   w_hs;
  logic   w_last;

  // Shared load-request decision used from IDLE, ERR and RUN.
  function automatic state_t decideStart(input logic [1:0] lsb, input logic [CNT_W-1:0] cnt);
    if (lsb != 2'b00 || cnt > c_depth) return S_ERR;
    else if (cnt == '0)                return S_PRIME;
    else                               return S_LOAD;
  endfunction

  assign w_hs   = r_inReady & inValid;
  assign w_last = (r_idx == r_count - 1'b1);

  // Next-state decode; every output is registered from this next state.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      S_IDLE, S_ERR, S_RUN: begin
        if (loadStart) begin
          w_start = 1'b1;
          w_next  = decideStart(baseAddr[1:0], wordCount);
        end
      end
      S_LOAD: begin
        if (w_hs && w_last) w_next = c_loadDone;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_hs) w_next = (inData == r_csum) ? S_PRIME : S_ERR;
      end
`endif
      S_PRIME: w_next = S_RUN;
      default: w_next = r_state;
    endcase
  end

  // State register, registered output decode and the write datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_count        <= '0;
      r_idx          <= '0;
      r_inReady      <= 1'b0;
      r_memWrEn      <= 1'b0;
      r_memWrAddr    <= '0;
      r_memWrData    <= '0;
      r_tbStart      <= 1'b0;
      r_initInstAddr <= '0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_inReady <= (w_next == S_LOAD) || (w_next == S_CHK);
      r_busy    <= (w_next == S_LOAD) || (w_next == S_CHK) || (w_next == S_PRIME);
      r_tbStart <= (w_next == S_RUN);
      // ERR is only left through an accepted loadStart, so this is sticky.
      r_error   <= (w_next == S_ERR);
      r_memWrEn <= 1'b0;

      if (w_start) begin
        r_base  <= baseAddr;
        r_count <= wordCount;
        r_idx   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        r_csum  <= '0;
`endif
      end

      if (r_state == S_LOAD && w_hs) begin
        r_memWrEn   <= 1'b1;
        r_memWrData <= inData;
        r_memWrAddr <= r_base + (32'(r_idx) << 2);
        r_idx       <= r_idx + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        r_csum      <= r_csum ^ inData;
`endif
      end

      // PC is presented during PRIME so the core captures it before release.
      if (w_next == S_PRIME) r_initInstAddr <= w_start ? baseAddr : r_base;
    end
  end

  assign inReady      = r_inReady;
  assign memWrEn      = r_memWrEn;
  assign memWrAddr    = r_memWrAddr;
  assign memWrData    = r_memWrData;
  assign tbStart      = r_tbStart;
  assign initInstAddr = r_initInstAddr;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule
`default_nettype wire
